piso_bit_feeder: RTL

- Parallel-in, serial-out feeder that sits directly upstream of the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per clock on bit_out. bit_out drives the detector's serial input.
- A one-word holding register lets consecutive words stream without gap bits, so detector sequences that straddle word boundaries are preserved.

---
 rtl/piso_bit_feeder.sv | 97 +++++++++
 1 files changed

// File: rtl/piso_bit_feeder.sv
// rtl/piso_bit_feeder.sv - parallel-in serial-out feeder with one-word holding register
module piso_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             accept;

    assign load_ready = ~hold_full;
    assign accept     = load_valid & ~hold_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_n;
            sh        <= sh_n;
            cnt       <= cnt_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
        end
    end

    always_comb begin
        state_n     = state;
        sh_n        = sh;
        cnt_n       = cnt;
        hold_n      = hold;
        hold_full_n = hold_full;
        case (state)
            IDLE: begin
                if (accept) begin
                    sh_n    = data_in;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    // Refill on the last-bit edge so consecutive words leave no gap bit.
                    cnt_n = '0;
                    if (hold_full) begin
                        sh_n        = hold;
                        hold_full_n = 1'b0;
                    end else if (accept) begin
                        sh_n = data_in;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    sh_n  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
                    cnt_n = cnt + 1'b1;
                    if (accept) begin
                        hold_n      = data_in;
                        hold_full_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bit_valid = (state == SHIFT);
        bit_out   = bit_valid & (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
        bit_last  = bit_valid & (cnt == LAST);
        busy      = bit_valid | hold_full;
    end

endmodule
